// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide sequencer.
//   - md_op_e    : operation encodings carried on the op port
//   - md_state_e : controller states
//   - MD_FIX_CYCLES / md_done_latency : cycles from start to done
package mips_md_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } md_state_e;

    // Cycles spent in the sign-fix state after the iterations finish.
    localparam int unsigned MD_FIX_CYCLES = 1;

    // Edges from the start edge to the HI/LO write edge.
    function automatic int unsigned md_done_latency(input int unsigned width);
        return width + MD_FIX_CYCLES;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of an unsigned shift-add multiply or restoring divide.
//   is_div   : 1 = divide step, 0 = multiply step
//   acc      : multiply: running product high half; divide: partial remainder
//   mq       : multiply: multiplier / product low half; divide: dividend / quotient
//   operand  : multiply: multiplicand magnitude; divide: divisor magnitude
//   acc_next : next accumulator
//   mq_next  : next multiplier/quotient register
module md_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mq_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        qbit    = (shifted >= {1'b0, operand});

        if (is_div) begin
            // Both branches fit in WIDTH bits: the remainder stays below the divisor.
            acc_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], qbit};
        end else begin
            // Carry of the add shifts into the high half, LSB into the low half.
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : issue strobe and operation (sampled only in idle)
//   src_a, src_b      : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo        : direct HI/LO writes of mt_data (idle only)
//   mf_req            : EX holds an MFHI/MFLO
//   hi, lo            : architectural HI/LO
//   busy              : operation in flight (registered)
//   done              : one-cycle pulse after HI/LO were written by mul/div
//   stall             : hazard-unit stall request
module mul_div_ctrl
    import mips_md_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CalcSteps = md_done_latency(WIDTH) - MD_FIX_CYCLES;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;
    logic             sgn_ab_q, sgn_ab_d;
    logic             sgn_a_q, sgn_a_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] acc_step, mq_step;

    // Operand magnitudes after sign extension to WIDTH+1 bits.
    logic             op_signed;
    logic             op_div;
    logic [WIDTH:0]   a_ext, b_ext;
    logic [WIDTH:0]   a_mag, b_mag;

    // Sign-fixed results.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .operand  (opnd_q),
        .acc_next (acc_step),
        .mq_next  (mq_step)
    );

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_ext     = {op_signed & src_a[WIDTH-1], src_a};
        b_ext     = {op_signed & src_b[WIDTH-1], src_b};
        a_mag     = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
        b_mag     = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;

        prod      = {acc_q, mq_q};
        prod_fix  = sgn_ab_q ? (~prod + 1'b1) : prod;
        quo_fix   = sgn_ab_q ? (~mq_q + 1'b1) : mq_q;
        rem_fix   = sgn_a_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        sgn_ab_d = sgn_ab_q;
        sgn_a_d  = sgn_a_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // start wins over a simultaneous mthi/mtlo
                    is_div_d = op_div;
                    div0_d   = op_div && (src_b == '0);
                    sgn_ab_d = a_ext[WIDTH] ^ b_ext[WIDTH];
                    sgn_a_d  = a_ext[WIDTH];
                    acc_d    = '0;
                    mq_d     = op_div ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
                    opnd_d   = op_div ? b_mag[WIDTH-1:0] : a_mag[WIDTH-1:0];
                    cnt_d    = CNT_W'(CalcSteps);
                    state_d  = StCalc;
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            StCalc: begin
                acc_d = acc_step;
                mq_d  = mq_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    // With a zero divisor every step subtracts nothing, so the
                    // remainder ends as |src_a| and its sign fix restores src_a
                    // exactly; only the quotient bypasses its fix.
                    hi_d = rem_fix;
                    lo_d = div0_q ? '1 : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            sgn_ab_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            sgn_ab_q <= sgn_ab_d;
            sgn_a_q  <= sgn_a_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (start | mf_req | mthi | mtlo);

endmodule
